// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//   Two-port arbiter in front of a single-port 128x32 SRAM with registered read
//   data. Port 0 is the fetch requester and port 1 is the data requester. Only
//   one transaction is in flight at a time. Each transaction holds the SRAM
//   enables for ACCESS_CYCLES cycles, spends one CAPTURE cycle, and then
//   returns a one-cycle done pulse.
//
// Handshake (req/gnt):
//   A requester raises pN_req with its command (we/addr/byte_sel/wdata) and
//   holds both stable until it sees pN_gnt. pN_gnt is combinational and is
//   asserted only in IDLE. The command is sampled only on the clock edge that
//   ends the grant cycle; anything the requester drives later is ignored.
//   Completion is reported by the registered pulse pN_done. For reads, pN_rdata
//   is valid in that same cycle.
//
// Parameters
//   ACCESS_CYCLES   cycles the SRAM enables are held per transaction (1..15)
//
// Ports
//   clk, reset                     clock; asynchronous active-high reset
//   pN_req/we/addr/byte_sel/wdata  command from requester N
//   pN_gnt                         command of port N accepted this cycle
//   pN_done, pN_rdata              completion pulse and registered read data
//   busy                           arbiter not idle
//   sram_*                         drive the SRAM macro; sram_dataout is its
//                                  registered read data
//   o_dbg_state                    current FSM state (IDLE=0, ACCESS=1,
//                                  CAPTURE=2)
// -----------------------------------------------------------------------------
module sram_arbiter #(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [6:0]  p0_addr,
  input  logic [3:0]  p0_byte_sel,
  input  logic [31:0] p0_wdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [6:0]  p1_addr,
  input  logic [3:0]  p1_byte_sel,
  input  logic [31:0] p1_wdata,
  output logic        p0_gnt,
  output logic        p0_done,
  output logic [31:0] p0_rdata,
  output logic        p1_gnt,
  output logic        p1_done,
  output logic [31:0] p1_rdata,
  output logic        busy,
  output logic [6:0]  sram_addr_sel,
  output logic [3:0]  sram_byte_sel,
  output logic [31:0] sram_datain,
  output logic        sram_read_enable,
  output logic        sram_write_enable,
  input  logic [31:0] sram_dataout,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_cnt;
  logic        r_last_p1;   // 1 = port 1 was granted most recently
  logic        r_port;      // port that owns the transaction in flight
  logic        r_we;
  logic [6:0]  r_addr;
  logic [3:0]  r_bsel;
  logic [31:0] r_wdata;
  logic        r_done0;
  logic        r_done1;
  logic [31:0] r_rdata0;
  logic [31:0] r_rdata1;

  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_sel_we;
  logic [6:0]  w_sel_addr;
  logic [3:0]  w_sel_bsel;
  logic [31:0] w_sel_wdata;

  // Next-state and grant logic. On a tie, the grant goes to the port that was
  // not granted last. Grants are held off while reset is high, because the
  // asynchronously cleared state already reads IDLE during reset.
  always_comb begin
    w_next_state = r_state;
    w_gnt0       = 1'b0;
    w_gnt1       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!reset) begin
          if (p0_req && (!p1_req || r_last_p1)) begin
            w_gnt0 = 1'b1;
          end else if (p1_req) begin
            w_gnt1 = 1'b1;
          end
        end
        if (w_gnt0 || w_gnt1) begin
          w_next_state = ACCESS;
        end
      end
      ACCESS: begin
        if (r_cnt == LAST_CNT) begin
          w_next_state = CAPTURE;
        end
      end
      CAPTURE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Command of the port being granted this cycle.
  always_comb begin
    w_sel_we    = w_gnt1 ? p1_we       : p0_we;
    w_sel_addr  = w_gnt1 ? p1_addr     : p0_addr;
    w_sel_bsel  = w_gnt1 ? p1_byte_sel : p0_byte_sel;
    w_sel_wdata = w_gnt1 ? p1_wdata    : p0_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= 4'd0;
      r_last_p1 <= 1'b1;
      r_port    <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= 7'd0;
      r_bsel    <= 4'd0;
      r_wdata   <= 32'd0;
      r_done0   <= 1'b0;
      r_done1   <= 1'b0;
      r_rdata0  <= 32'd0;
      r_rdata1  <= 32'd0;
    end else begin
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;

      if (w_gnt0 || w_gnt1) begin
        r_port    <= w_gnt1;
        r_last_p1 <= w_gnt1;
        r_we      <= w_sel_we;
        r_addr    <= w_sel_addr;
        r_bsel    <= w_sel_bsel;
        r_wdata   <= w_sel_wdata;
        r_cnt     <= 4'd0;
      end

      if (r_state == ACCESS) begin
        r_cnt <= (r_cnt == LAST_CNT) ? 4'd0 : r_cnt + 4'd1;
      end

      // sram_dataout was loaded on the last ACCESS edge, so it is valid
      // throughout CAPTURE.
      if (r_state == CAPTURE) begin
        if (r_port) begin
          r_done1 <= 1'b1;
          if (!r_we) begin
            r_rdata1 <= sram_dataout;
          end
        end else begin
          r_done0 <= 1'b1;
          if (!r_we) begin
            r_rdata0 <= sram_dataout;
          end
        end
      end
    end
  end

  // SRAM drive. Everything except the address is quiet outside ACCESS, and
  // only one of the two enables can be high.
  always_comb begin
    sram_read_enable  = 1'b0;
    sram_write_enable = 1'b0;
    sram_byte_sel     = 4'd0;
    sram_datain       = 32'd0;
    if (r_state == ACCESS) begin
      sram_read_enable  = !r_we;
      sram_write_enable = r_we;
      sram_byte_sel     = r_bsel;
      sram_datain       = r_we ? r_wdata : 32'd0;
    end
  end

  assign sram_addr_sel = r_addr;
  assign p0_gnt        = w_gnt0;
  assign p1_gnt        = w_gnt1;
  assign p0_done       = r_done0;
  assign p1_done       = r_done1;
  assign p0_rdata      = r_rdata0;
  assign p1_rdata      = r_rdata1;
  assign busy          = (r_state != IDLE);
  assign o_dbg_state   = r_state;

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ACCESS_CYCLES, default 2, number of consecutive cycles SRAM enables are held per transaction (legal 1..15).
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; forces all state and registered outputs to reset values immediately.
REQ-004 p0_req / p1_req  input  1  requester N has a transaction pending (port 0 = fetch, port 1 = data).
REQ-005 pN_we  input  1  1 = write, 0 = read.
REQ-006 pN_addr  input  7  word address, 0..127.
REQ-007 pN_byte_sel  input  4  byte lane enables, bit k = bits [8k+7:8k].
REQ-008 pN_wdata  input  32  write data.
REQ-009 pN_gnt  output  1  combinational; command of port N accepted this cycle.
REQ-010 pN_done  output  1  registered one-cycle pulse; port N transaction complete.
REQ-011 pN_rdata  output  32  registered read data, valid when pN_done=1 for a read.
REQ-012 busy  output  1  state != IDLE.
REQ-013 sram_addr_sel  output  7 / sram_byte_sel  output  4 / sram_datain  output  32 / sram_read_enable  output  1 / sram_write_enable  output  1  drive the 128x32 SRAM ports of the same names.
REQ-014 sram_dataout  input  32  SRAM registered read data.

Function
REQ-015 FSM states IDLE, ACCESS, CAPTURE; one transaction in flight at a time.
REQ-016 IDLE: if any req, assert exactly one pN_gnt this cycle, latch that port's we/addr/byte_sel/wdata and port id, go to ACCESS; else stay.
REQ-017 Arbitration: single requester always granted; both requesting -> grant port not granted last; last-granted pointer resets to 1 (port 0 wins first tie).
REQ-018 ACCESS: lasts exactly ACCESS_CYCLES cycles (4-bit counter); sram_addr_sel/sram_byte_sel = latched values; sram_read_enable = !we, sram_write_enable = we; sram_datain = latched wdata for writes, 0 for reads; then go to CAPTURE.
REQ-019 CAPTURE: one cycle, all sram enables 0, sram_addr_sel held; at end of cycle load pN_rdata of the latched port from sram_dataout (reads only), set pN_done=1 for next cycle, go to IDLE.
REQ-020 Timing: gnt in cycle T -> enables high T+1..T+ACCESS_CYCLES, CAPTURE at T+ACCESS_CYCLES+1, pN_done at T+ACCESS_CYCLES+2 (default 4); writes use identical timing.
REQ-021 pN_done cycle coincides with IDLE; a new grant is permitted in that same cycle (throughput one transaction per ACCESS_CYCLES+2 cycles).
REQ-022 pN_gnt is 0 outside IDLE; requests arriving while busy wait, with no queueing beyond the req level.
REQ-023 Requester holds req and command stable until gnt; command is sampled only in the grant cycle; later changes are ignored.
REQ-024 pN_rdata holds its value until the next read completion for that port; writes leave pN_rdata unchanged.
REQ-025 Outside ACCESS all sram enables = 0, sram_datain = 0; read and write enable are never high together.
REQ-026 Addresses 0 and 127 and byte_sel 0 are passed through unmodified; no range checking.

Reset
REQ-027 On reset assertion, asynchronously: state IDLE, counter 0, pointer 1, sram_* outputs 0, pN_done 0, pN_rdata 0, busy 0, pN_gnt 0 while reset high.
REQ-028 Reset during ACCESS or CAPTURE aborts the transaction: no pN_done is produced, and the write may be partial at the SRAM.
REQ-029 First grant is possible in the first IDLE cycle after reset deasserts.

Verification
REQ-030 Write/read: p0 write addr 0x05, byte_sel 0xF, data 0xDEADBEEF, then p0 read 0x05 -> p0_done at T+4 both times, p0_rdata = 0xDEADBEEF.
REQ-031 Tie: both req from reset, continuously -> grants p0, p1, p0, p1 at 4-cycle spacing, and the done port matches the grant port.
REQ-032 Busy wait: p1_req rises at T+1 during a p0 transaction granted at T -> p1_gnt not before T+4, and p1_gnt at T+4 coincides with p0_done.
REQ-033 Byte lanes/boundary: write 0x11223344 to addr 0x7F, then write byte_sel 4'b0010 data 0x0000AA00, then read 0x7F -> p1_rdata = 0x1122AA44.
REQ-034 Reset mid-ACCESS: assert reset at T+1 of a write -> sram_write_enable = 0 the same cycle, no done pulse, busy = 0, next tie grants p0.
REQ-035 ACCESS_CYCLES=1: read granted at T -> sram_read_enable high only at T+1, p0_done at T+3.
